// File: rtl/sf_pattern_engine.sv
// Test-pattern generator and read-back checker for the serial-flash tester.
// Streams additive or LFSR words for programming and counts read-back mismatches.
module sf_pattern_engine #(
    parameter int                         PARM_DATA_WIDTH    = 8,
    parameter int                         PARM_ADDR_WIDTH    = 25,
    parameter int                         PARM_PATTERN_COUNT = 4,
    parameter logic [PARM_DATA_WIDTH-1:0] PARM_LFSR_TAPS     = 8'hB8,
    localparam int                        SEL_W = (PARM_PATTERN_COUNT > 1) ? $clog2(PARM_PATTERN_COUNT) : 1
) (
    input  logic                       i_clk_20mhz,
    input  logic                       i_rst_20mhz,
    input  logic                       i_start,
    input  logic                       i_check,
    input  logic                       i_mode_lfsr,
    input  logic [SEL_W-1:0]           i_pattern_sel,
    input  logic [PARM_ADDR_WIDTH-1:0] i_start_addr,
    input  logic [PARM_ADDR_WIDTH:0]   i_byte_count,
    output logic                       o_gen_valid,
    output logic [PARM_DATA_WIDTH-1:0] o_gen_data,
    input  logic                       i_gen_ready,
    input  logic                       i_chk_valid,
    input  logic [PARM_DATA_WIDTH-1:0] i_chk_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [PARM_ADDR_WIDTH-1:0] o_cur_addr,
    output logic [31:0]                o_err_count,
    output logic                       o_first_err_valid,
    output logic [PARM_ADDR_WIDTH-1:0] o_first_err_addr
);

    localparam int W     = PARM_DATA_WIDTH;
    localparam int CNT_W = PARM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_CHK,
        ST_DONE
    } state_t;

    state_t           state;
    logic             cfg_lfsr;
    logic [W-1:0]     cfg_incr;
    logic [CNT_W-1:0] count;

    logic [SEL_W-1:0] sel_eff;
    logic [W-1:0]     start_word;
    logic [W-1:0]     incr_word;
    logic [W-1:0]     seed_word;
    logic [W-1:0]     lfsr_next;
    logic [W-1:0]     next_word;
    logic             last_word;
    logic             mismatch;

    // Out-of-range selections fall back to pattern 0.
    assign sel_eff    = (int'(i_pattern_sel) < PARM_PATTERN_COUNT) ? i_pattern_sel : '0;
    assign start_word = W'(sel_eff) << 3;
    assign incr_word  = (sel_eff == '0) ? W'(1) : start_word - W'(1);
    assign seed_word  = (i_mode_lfsr && start_word == '0) ? W'(1) : start_word;

    // The pattern register doubles as the expected word during a check pass.
    assign lfsr_next  = (o_gen_data >> 1) ^ (o_gen_data[0] ? PARM_LFSR_TAPS : '0);
    assign next_word  = cfg_lfsr ? lfsr_next : o_gen_data + cfg_incr;
    assign last_word  = (count == CNT_W'(1));
    assign mismatch   = (i_chk_data != o_gen_data);

    // NOTE: every register here uses <= so all next-state terms see pre-edge values.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state             <= ST_IDLE;
            cfg_lfsr          <= 1'b0;
            cfg_incr          <= '0;
            count             <= '0;
            o_gen_valid       <= 1'b0;
            o_gen_data        <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_cur_addr        <= '0;
            o_err_count       <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_addr  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        cfg_lfsr   <= i_mode_lfsr;
                        cfg_incr   <= incr_word;
                        o_gen_data <= seed_word;
                        o_cur_addr <= i_start_addr;
                        count      <= i_byte_count;
                        o_busy     <= 1'b1;
                        if (i_byte_count == '0) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else if (i_check) begin
                            state             <= ST_CHK;
                            o_err_count       <= '0;
                            o_first_err_valid <= 1'b0;
                            o_first_err_addr  <= '0;
                        end else begin
                            state       <= ST_GEN;
                            o_gen_valid <= 1'b1;
                        end
                    end
                end

                ST_GEN: begin
                    if (i_gen_ready) begin
                        o_gen_data <= next_word;
                        o_cur_addr <= o_cur_addr + 1'b1;
                        count      <= count - 1'b1;
                        if (last_word) begin
                            state       <= ST_DONE;
                            o_gen_valid <= 1'b0;
                            o_done      <= 1'b1;
                        end
                    end
                end

                ST_CHK: begin
                    if (i_chk_valid) begin
                        if (mismatch) begin
                            if (o_err_count != '1) begin
                                o_err_count <= o_err_count + 1'b1;
                            end
                            if (!o_first_err_valid) begin
                                o_first_err_valid <= 1'b1;
                                o_first_err_addr  <= o_cur_addr;
                            end
                        end
                        o_gen_data <= next_word;
                        o_cur_addr <= o_cur_addr + 1'b1;
                        count      <= count - 1'b1;
                        if (last_word) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sf_pattern_engine.sv
// Directed bench for sf_pattern_engine with a queue-based scoreboard for generated words.
module tb_sf_pattern_engine;

    localparam int AW = 25;

    typedef struct packed {
        logic [7:0]    data;
        logic [AW-1:0] addr;
    } exp_t;

    logic          i_clk_20mhz = 1'b0;
    logic          i_rst_20mhz = 1'b1;
    logic          i_start = 1'b0;
    logic          i_check = 1'b0;
    logic          i_mode_lfsr = 1'b0;
    logic [1:0]    i_pattern_sel = '0;
    logic [AW-1:0] i_start_addr = '0;
    logic [AW:0]   i_byte_count = '0;
    logic          o_gen_valid;
    logic [7:0]    o_gen_data;
    logic          i_gen_ready = 1'b0;
    logic          i_chk_valid = 1'b0;
    logic [7:0]    i_chk_data = '0;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_cur_addr;
    logic [31:0]   o_err_count;
    logic          o_first_err_valid;
    logic [AW-1:0] o_first_err_addr;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    sf_pattern_engine dut (
        .i_clk_20mhz       (i_clk_20mhz),
        .i_rst_20mhz       (i_rst_20mhz),
        .i_start           (i_start),
        .i_check           (i_check),
        .i_mode_lfsr       (i_mode_lfsr),
        .i_pattern_sel     (i_pattern_sel),
        .i_start_addr      (i_start_addr),
        .i_byte_count      (i_byte_count),
        .o_gen_valid       (o_gen_valid),
        .o_gen_data        (o_gen_data),
        .i_gen_ready       (i_gen_ready),
        .i_chk_valid       (i_chk_valid),
        .i_chk_data        (i_chk_data),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_cur_addr        (o_cur_addr),
        .o_err_count       (o_err_count),
        .o_first_err_valid (o_first_err_valid),
        .o_first_err_addr  (o_first_err_addr)
    );

    always #25 i_clk_20mhz = ~i_clk_20mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk_20mhz);
        #1;
    endtask

    // Reference pattern model, written directly from the pattern definitions.
    function automatic logic [7:0] m_start(input int k);
        return 8'((8 * k) % 256);
    endfunction

    function automatic logic [7:0] m_incr(input int k);
        return (k == 0) ? 8'd1 : 8'((8 * k - 1) % 256);
    endfunction

    function automatic logic [7:0] m_seed(input int k, input bit lfsr);
        return (lfsr && m_start(k) == 8'd0) ? 8'd1 : m_start(k);
    endfunction

    function automatic logic [7:0] m_next(input logic [7:0] cur, input bit lfsr, input int k);
        if (lfsr) return (cur >> 1) ^ (cur[0] ? 8'hB8 : 8'h00);
        return cur + m_incr(k);
    endfunction

    task automatic push_words(input int k, input bit lfsr, input logic [AW-1:0] addr, input int n);
        exp_t          e;
        logic [7:0]    w;
        logic [AW-1:0] a;
        w = m_seed(k, lfsr);
        a = addr;
        for (int i = 0; i < n; i++) begin
            e.data = w;
            e.addr = a;
            exp_q.push_back(e);
            w = m_next(w, lfsr, k);
            a = a + 1'b1;
        end
    endtask

    task automatic start_pass(input bit chk, input bit lfsr, input logic [1:0] sel,
                              input logic [AW-1:0] addr, input logic [AW:0] cnt);
        i_check       = chk;
        i_mode_lfsr   = lfsr;
        i_pattern_sel = sel;
        i_start_addr  = addr;
        i_byte_count  = cnt;
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, o_gen_valid, 0);
        check({tag, "_data"}, o_gen_data, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_addr"}, o_cur_addr, 0);
        check({tag, "_errcnt"}, o_err_count, 0);
        check({tag, "_fvalid"}, o_first_err_valid, 0);
        check({tag, "_faddr"}, o_first_err_addr, 0);
    endtask

    // Drives i_gen_ready (held or toggling), pops the scoreboard on every handshake.
    task automatic run_gen(input string tag, input bit toggle, input int exp_cycles);
        int         cyc;
        int         extra;
        bit         rdy;
        bit         hold_v;
        logic [7:0] hold_d;
        exp_t       e;
        cyc    = 0;
        extra  = 0;
        rdy    = 1'b1;
        hold_v = 1'b0;
        hold_d = '0;
        while (o_done !== 1'b1 && cyc < 200) begin
            if (hold_v) check({tag, "_hold"}, o_gen_data, hold_d);
            i_gen_ready = rdy;
            hold_v      = o_gen_valid && !rdy;
            hold_d      = o_gen_data;
            if (o_gen_valid && rdy) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_data"}, o_gen_data, e.data);
                    check({tag, "_addr"}, o_cur_addr, e.addr);
                end else begin
                    extra++;
                end
            end
            tick();
            cyc++;
            if (toggle) rdy = !rdy;
        end
        i_gen_ready = 1'b0;
        check({tag, "_done"}, o_done, 1);
        check({tag, "_cycles"}, cyc, exp_cycles);
        check({tag, "_busy_in_done"}, o_busy, 1);
        check({tag, "_valid_dropped"}, o_gen_valid, 0);
        check({tag, "_extra_words"}, extra, 0);
        check({tag, "_leftover"}, exp_q.size(), 0);
        tick();
        check({tag, "_done_pulse"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
    endtask

    logic [7:0] w;

    initial begin
        // Reset values.
        tick();
        tick();
        check_reset_values("reset");
        i_rst_20mhz = 1'b0;
        tick();

        // Pattern 1 additive, five words, consumer always ready.
        push_words(1, 1'b0, '0, 5);
        start_pass(1'b0, 1'b0, 2'd1, '0, 5);
        check("p1_busy", o_busy, 1);
        run_gen("p1", 1'b0, 5);

        // Pattern 0 with back-pressure on every other cycle.
        push_words(0, 1'b0, '0, 4);
        start_pass(1'b0, 1'b0, 2'd0, '0, 4);
        run_gen("p0_bp", 1'b1, 7);

        // Check pass across the top of the device with two corrupted words.
        start_pass(1'b1, 1'b0, 2'd3, 25'h1FF_FF80, 256);
        w = m_seed(3, 1'b0);
        for (int n = 0; n < 256; n++) begin
            i_chk_valid = 1'b1;
            i_chk_data  = (n == 100 || n == 200) ? ~w : w;
            if (n == 0)   check("chk_cleared", o_err_count, 0);
            if (n == 128) check("chk_addr_wrap", o_cur_addr, 0);
            if (n == 101) begin
                check("chk_first_cnt", o_err_count, 1);
                check("chk_first_valid", o_first_err_valid, 1);
            end
            tick();
            w = m_next(w, 1'b0, 3);
        end
        i_chk_valid = 1'b0;
        check("chk_done", o_done, 1);
        check("chk_err_count", o_err_count, 2);
        check("chk_first_addr", o_first_err_addr, 25'h1FF_FFE4);
        tick();
        check("chk_idle", o_busy, 0);

        // LFSR pattern 0; the generate pass must leave the error results alone.
        push_words(0, 1'b1, 25'h10, 3);
        start_pass(1'b0, 1'b1, 2'd0, 25'h10, 3);
        run_gen("lfsr", 1'b0, 3);
        check("retain_err_count", o_err_count, 2);
        check("retain_first_addr", o_first_err_addr, 25'h1FF_FFE4);

        // Zero-length pass.
        i_gen_ready = 1'b1;
        start_pass(1'b0, 1'b0, 2'd2, 25'h20, 0);
        check("zero_done", o_done, 1);
        check("zero_valid", o_gen_valid, 0);
        tick();
        check("zero_done_pulse", o_done, 0);
        check("zero_valid_after", o_gen_valid, 0);
        check("zero_idle", o_busy, 0);
        i_gen_ready = 1'b0;

        // A second i_start during a busy pass must be ignored.
        push_words(2, 1'b0, 25'h40, 3);
        start_pass(1'b0, 1'b0, 2'd2, 25'h40, 3);
        start_pass(1'b0, 1'b0, 2'd0, 25'h0, 10);
        check("busy_start_data", o_gen_data, 8'h10);
        check("busy_start_addr", o_cur_addr, 25'h40);
        run_gen("busy_start", 1'b0, 3);
        tick();
        check("busy_start_no_restart", o_gen_valid, 0);

        // Reset in the middle of a check pass with every word corrupted.
        start_pass(1'b1, 1'b0, 2'd2, 25'h100, 20);
        check("abort_cleared_cnt", o_err_count, 0);
        check("abort_cleared_valid", o_first_err_valid, 0);
        w = m_seed(2, 1'b0);
        for (int n = 0; n < 5; n++) begin
            i_chk_valid = 1'b1;
            i_chk_data  = w ^ 8'h01;
            tick();
            w = m_next(w, 1'b0, 2);
        end
        check("abort_err_count", o_err_count, 5);
        check("abort_first_addr", o_first_err_addr, 25'h100);
        check("abort_cur_addr", o_cur_addr, 25'h105);
        i_chk_valid = 1'b0;
        i_rst_20mhz = 1'b1;
        tick();
        check_reset_values("abort_reset");
        i_rst_20mhz = 1'b0;
        tick();
        check("abort_no_done", o_done, 0);
        check("abort_no_busy", o_busy, 0);

        // Clean LFSR check pass after the abort, wrapping the address.
        start_pass(1'b1, 1'b1, 2'd0, 25'h1FF_FFFE, 10);
        w = m_seed(0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            i_chk_valid = 1'b1;
            i_chk_data  = w;
            if (n == 2) check("post_addr_wrap", o_cur_addr, 0);
            tick();
            w = m_next(w, 1'b1, 0);
        end
        i_chk_valid = 1'b0;
        check("post_done", o_done, 1);
        check("post_err_count", o_err_count, 0);
        check("post_first_valid", o_first_err_valid, 0);
        tick();
        check("post_idle", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sf_pattern_engine.md
# sf_pattern_engine

Parametrised test-pattern generator and read-back checker for the serial-flash tester. It produces the byte stream that the tester FSM feeds into page-program commands and verifies the stream returned by read commands against the same sequence. It generalises the fixed four-pattern additive scheme to N selectable patterns, a configurable data width and an added LFSR mode, and it accumulates error statistics. It sits between the tester FSM and the flash command/data FIFOs.

## Interface
- PARM_DATA_WIDTH, 8: width of one pattern word.
- PARM_ADDR_WIDTH, 25: byte-address width; 25 gives 32 MiB (256 Mbit).
- PARM_PATTERN_COUNT, 4: number of selectable patterns, ≥1.
- PARM_LFSR_TAPS, 8'hB8: Galois LFSR tap mask, PARM_DATA_WIDTH bits.

Ports:
- i_clk_20mhz  in  1  system clock; single clock domain.
- i_rst_20mhz  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a pass; sampled only in ST_IDLE.
- i_check  in  1  0 = generate pass, 1 = check pass; latched at i_start.
- i_mode_lfsr  in  1  0 = additive pattern, 1 = LFSR pattern; latched at i_start.
- i_pattern_sel  in  max(1,$clog2(PARM_PATTERN_COUNT))  pattern index; latched at i_start.
- i_start_addr  in  PARM_ADDR_WIDTH  first byte address of the pass; latched at i_start.
- i_byte_count  in  PARM_ADDR_WIDTH+1  number of words in the pass; latched at i_start.
- o_gen_valid  out  1  generated word is available.
- o_gen_data  out  PARM_DATA_WIDTH  generated word.
- i_gen_ready  in  1  consumer accepts the word.
- i_chk_valid  in  1  read-back word is present.
- i_chk_data  in  PARM_DATA_WIDTH  read-back word.
- o_busy  out  1  a pass is in progress.
- o_done  out  1  one-cycle pulse at the end of a pass.
- o_cur_addr  out  PARM_ADDR_WIDTH  address of the word currently being offered or expected.
- o_err_count  out  32  mismatch count for the current or last check pass; saturates at 32'hFFFF_FFFF.
- o_first_err_valid  out  1  a mismatch has been captured.
- o_first_err_addr  out  PARM_ADDR_WIDTH  address of the first mismatch.

## Operation
- Pattern k, additive mode:
  - start_k = (8·k) mod 2^W.
  - incr_k = 1 when k = 0, otherwise (8·k − 1) mod 2^W.
  - Word n = start_k + n·incr_k mod 2^W.
  - For k = 0..3 this gives 00/01, 08/07, 10/0F, 18/17.
- Pattern k, LFSR mode:
  - Seed is start_k, replaced by 1 when start_k is 0.
  - Next = (cur >> 1) XOR (cur[0] ? PARM_LFSR_TAPS : 0).
- An i_pattern_sel value ≥ PARM_PATTERN_COUNT is treated as pattern 0.
- The sequence depends only on the offset n from the start of the pass, not on the absolute address.
- FSM states: ST_IDLE, ST_GEN, ST_CHK, ST_DONE.
  - ST_IDLE with i_start: latch the configuration, load the pattern register with word 0, set the address to i_start_addr and the remaining count to i_byte_count.
    - If the count is 0, go to ST_DONE.
    - Otherwise, go to ST_CHK when i_check = 1, else ST_GEN.
  - On entering ST_CHK: clear o_err_count, o_first_err_valid and o_first_err_addr.
  - ST_GEN: o_gen_valid = 1. Each cycle with i_gen_ready = 1 is a handshake: advance the pattern, increment the address, decrement the count. When the count reaches 0, go to ST_DONE.
  - ST_CHK: each cycle with i_chk_valid = 1:
    - Compare i_chk_data to the expected word.
    - On a mismatch, increment o_err_count (saturating). If o_first_err_valid is 0, capture o_cur_addr and set o_first_err_valid.
    - Advance the pattern, address and count. When the count reaches 0, go to ST_DONE.
  - ST_DONE: o_done = 1 for one cycle, then return to ST_IDLE.
- Address arithmetic is modulo 2^PARM_ADDR_WIDTH, so the address wraps from the top of the device to 0.
- In ST_IDLE, i_gen_ready and i_chk_valid are ignored.
- i_start is ignored while o_busy = 1.
- Error results are retained after a check pass until the next check pass starts; a generate pass does not clear them.

## Timing
- Reset values:
  - State ST_IDLE.
  - o_gen_valid, o_busy, o_done, o_first_err_valid = 0.
  - o_gen_data, o_cur_addr, o_err_count, o_first_err_addr = 0.
- Reset applied mid-pass aborts the pass on the next clock edge with no o_done.
- o_busy = 1 from the cycle after i_start through the ST_DONE cycle inclusive.
- Generate pass:
  - o_gen_valid and the first o_gen_data appear the cycle after i_start.
  - o_gen_data changes only on the cycle after a handshake.
  - Sustained throughput is one word per clock.
  - o_gen_valid drops the cycle after the last handshake; o_done is asserted in that same cycle.
- Check pass:
  - A word can be accepted starting the cycle after i_start.
  - o_err_count and o_first_err_* update on the cycle after the offending word.
  - o_done is asserted the cycle after the last word, and the error outputs are final in that cycle.
- i_byte_count = 0: o_done is asserted 1 cycle after i_start and no words are transferred.

## Test plan
- Generate, pattern 1, additive, start address 0, count 5, i_gen_ready held at 1 → o_gen_data = 08, 0F, 16, 1D, 24 on consecutive cycles; o_done one cycle after the last word.
- Generate, pattern 0, count 4, i_gen_ready toggling 1,0,1,0,… → words 00, 01, 02, 03, each held stable while i_gen_ready = 0; o_cur_addr steps 0→3.
- Check, pattern 3, count 256, one word corrupted at offset 100 and one at offset 200, start address 0x1FFFF80 → o_err_count = 2, o_first_err_addr = 0x1FFFFE4; o_cur_addr wraps to 0 at offset 128.
- LFSR mode, pattern 0, count 3 → seed 01, then B8, then 5C.
- i_start with i_byte_count = 0 → o_done one cycle later, o_gen_valid never asserted; a second i_start during a busy pass is ignored.
- Reset asserted mid check pass → all outputs at reset values the next cycle, no o_done; a new pass then runs correctly.
